linebuf_col_gen: RTL and testbench
==================================

// Module: linebuf_col_gen
// PURPOSE
//  Streaming line buffer that produces the vertical M_DEPTH-pixel column vector
//  consumed by the 3x3 convolution filters (gauss/sobel) in the HDMI video path.
//  Takes one pixel per clock with dv/hs/vs and stores the last M_DEPTH-1 lines.
//  Outputs the current pixel plus the same column of the previous lines,
//  with dv/hs/vs delayed to stay aligned with the vector.
// PARAMETERS
//  COLORDEPTH  8     bits per pixel component
//  M_DEPTH     3     column vector height (rows); M_DEPTH-1 line memories
//  LINE_W      1920  max pixels per line (memory depth)
//  ADDR_W      $clog2(LINE_W)  column address width (derived, do not override)
// PORTS
//  clk         in   1             pixel clock
//  rst_n       in   1             synchronous reset, active low
//  px_i        in   COLORDEPTH    incoming pixel, valid when dv_i=1
//  dv_i        in   1             data valid
//  hs_i        in   1             hsync
//  vs_i        in   1             vsync
//  vect_o      out  COLORDEPTH x M_DEPTH  [0]=current line, [k]=line n-k, same column
//  dv_o        out  1             dv_i delayed 2 cycles
//  hs_o        out  1             hs_i delayed 2 cycles
//  vs_o        out  1             vs_i delayed 2 cycles
//  ovf_o       out  1             sticky: line exceeded LINE_W pixels in this frame
// BEHAVIOUR
//  - One clock (clk); reset synchronous, active-low (rst_n). rst_n=0: vect_o, dv_o, hs_o,
//    vs_o, ovf_o = 0 at next edge; col_cnt, line_cnt, wr_sel, delay pipes = 0.
//    Memory contents are not cleared; they are masked by line_cnt.
//  - Latency: px_i at cycle t -> vect_o at t+2 (memory read reg, output reg).
//  - col_cnt: increments on each dv_i=1 cycle; cleared on dv falling edge and on vs rising.
//    Saturates at LINE_W-1; further dv_i pixels are not written and set ovf_o.
//  - N=M_DEPTH-1 read-first line memories. Each dv_i cycle: mem[wr_sel][col_cnt] <= px_i;
//    all mems are read at col_cnt. vect_o[k] = rd[(wr_sel-k) mod N], k=1..N.
//    vect_o[0] = px_i delayed 2.
//  - Line end = dv falling edge: wr_sel <= (wr_sel+1) mod N.
//    line_cnt <= min(line_cnt+1, N).
//  - vs_i rising edge: line_cnt, wr_sel, col_cnt <= 0; ovf_o cleared.
//    vs rise and dv fall in the same cycle: vs wins, all counters = 0.
//  - Row masking: vect_o[k] = 0 while line_cnt (sampled with the pixel) < k
//    (top-of-frame rows).
//  - Shorter line than previous: stale columns beyond it are never output.
//    No special handling.
//  - dv_i=0: memories not written; vect_o still follows pipeline; dv_o marks validity.
// CONFIGURATION
//  - LINEBUF_EDGE_REP_EN defined: masked rows replicate the nearest valid row
//    (vect_o[k] = vect_o[line_cnt]) instead of 0, for border handling.
//  - Undefined: masked rows output 0.
// STRUCTURE
//  - Package linebuf_pkg: pixel_t typedef (logic [COLORDEPTH-1:0]), default
//    COLORDEPTH/M_DEPTH/LINE_W constants. Shared with conv blocks.
//  - Sub-module line_mem: single-port read-first RAM, 1-cycle read latency,
//    depth LINE_W. Instantiated N times in a generate loop.
//  - Top holds counters, edge detectors, wr_sel rotation, mask/mux, sync delay pipe.
// TESTING
//  1. Reset: pulse rst_n=0 mid-line -> all outputs 0 next cycle.
//     Next line after vs treated as line 0.
//  2. M_DEPTH=3, 3 lines of 4 px, px=16*line+col: line 2 col 1 -> vect_o={0x01,0x11,0x21}
//     ([2],[1],[0]) 2 cycles after input.
//  3. Top rows: line 0 -> vect_o[1]=vect_o[2]=0; line 1 -> vect_o[2]=0.
//     With LINEBUF_EDGE_REP_EN, same rows equal vect_o[0] / vect_o[1].
//  4. LINE_W=8, 10-pixel line -> ovf_o=1 from 9th pixel; held through frame;
//     cleared on next vs rise.
//  5. vs rise coincident with dv fall -> line_cnt=0, wr_sel=0.
//     Next line outputs masked rows.
//  6. Sync alignment: single-cycle hs_i/vs_i/dv_i pulses -> hs_o/vs_o/dv_o
//     pulses exactly 2 cycles later, aligned with vect_o.

Source files
------------

// File: rtl/linebuf_pkg.sv
// Shared definitions for the line-buffer / convolution blocks: default geometry,
// pixel type, sync bundle and the line-memory ring index helper.
package linebuf_pkg;

  localparam int LB_COLORDEPTH = 8;
  localparam int LB_M_DEPTH    = 3;
  localparam int LB_LINE_W     = 1920;

  typedef logic [LB_COLORDEPTH-1:0] pixel_t;

  typedef struct packed {
    logic dv;
    logic hs;
    logic vs;
  } sync_t;

  // Memory holding line n-k when line n is being written into slot sel of an n-deep ring.
  function automatic int ring_idx(input int sel, input int k, input int n);
    return (sel + n - k) % n;
  endfunction

endpackage

// File: rtl/linebuf_col_gen_if.sv
// Video stream port of the column generator: pixel/sync in, column vector/sync/overflow out.
interface linebuf_col_gen_if
  import linebuf_pkg::*;
#(
  parameter int COLORDEPTH = LB_COLORDEPTH,
  parameter int M_DEPTH    = LB_M_DEPTH
);

  logic [COLORDEPTH-1:0]              px_i;
  logic                               dv_i;
  logic                               hs_i;
  logic                               vs_i;
  logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_o;
  logic                               dv_o;
  logic                               hs_o;
  logic                               vs_o;
  logic                               ovf_o;

  modport master (
    output px_i, dv_i, hs_i, vs_i,
    input  vect_o, dv_o, hs_o, vs_o, ovf_o
  );

  modport slave (
    input  px_i, dv_i, hs_i, vs_i,
    output vect_o, dv_o, hs_o, vs_o, ovf_o
  );

endinterface

// File: rtl/line_mem.sv
// Single-port read-first line memory with a registered read (one cycle latency).
module line_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1920,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Read returns the pre-write contents, i.e. the line stored one ring lap ago.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/linebuf_col_gen.sv
// Streaming line buffer producing an M_DEPTH-tall pixel column with 2-cycle aligned sync.
// Optional LINEBUF_EDGE_REP_EN: top-of-frame rows replicate the nearest valid row instead of 0.
module linebuf_col_gen
  import linebuf_pkg::*;
#(
  parameter int COLORDEPTH = LB_COLORDEPTH,
  parameter int M_DEPTH    = LB_M_DEPTH,
  parameter int LINE_W     = LB_LINE_W
) (
  input logic              clk,
  input logic              rst_n,
  linebuf_col_gen_if.slave bus
);

  localparam int N      = M_DEPTH - 1;
  localparam int ADDR_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam int SEL_W  = (N > 1) ? $clog2(N) : 1;
  localparam int LC_W   = $clog2(N + 1);

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(LINE_W - 1);
  localparam logic [SEL_W-1:0]  SEL_LAST = SEL_W'(N - 1);
  localparam logic [LC_W-1:0]   LC_MAX   = LC_W'(N);

  logic [ADDR_W-1:0]                  col_cnt_reg,  col_cnt_next;
  logic                               col_full_reg, col_full_next;
  logic [LC_W-1:0]                    line_cnt_reg, line_cnt_next;
  logic [SEL_W-1:0]                   wr_sel_reg,   wr_sel_next;
  logic                               ovf_reg,      ovf_next;
  sync_t                              sync_p1_reg;
  sync_t                              sync_o_reg;
  logic                               ovf_o_reg;
  logic [COLORDEPTH-1:0]              px_p1_reg;
  logic [LC_W-1:0]                    lc_p1_reg;
  logic [SEL_W-1:0]                   sel_p1_reg;
  logic [M_DEPTH-1:0][COLORDEPTH-1:0] vect_reg;

  logic                  dv_fall;
  logic                  vs_rise;
  logic                  wr_en;
  logic [COLORDEPTH-1:0] rd_data   [N];
  logic [COLORDEPTH-1:0] row_cand  [M_DEPTH];
  logic [COLORDEPTH-1:0] vect_next [M_DEPTH];
  logic [COLORDEPTH-1:0] row_fill;

  // The first sync pipe stage doubles as the previous-cycle sample for edge detection.
  assign dv_fall = sync_p1_reg.dv & ~bus.dv_i;
  assign vs_rise = bus.vs_i & ~sync_p1_reg.vs;
  assign wr_en   = bus.dv_i & ~col_full_reg;

  always_comb begin
    col_cnt_next  = col_cnt_reg;
    col_full_next = col_full_reg;
    line_cnt_next = line_cnt_reg;
    wr_sel_next   = wr_sel_reg;
    ovf_next      = ovf_reg;
    if (vs_rise) begin
      col_cnt_next  = '0;
      col_full_next = 1'b0;
      line_cnt_next = '0;
      wr_sel_next   = '0;
      ovf_next      = 1'b0;
    end else begin
      if (dv_fall) begin
        col_cnt_next  = '0;
        col_full_next = 1'b0;
        line_cnt_next = (line_cnt_reg == LC_MAX) ? LC_MAX : line_cnt_reg + 1'b1;
        wr_sel_next   = (wr_sel_reg == SEL_LAST) ? '0 : wr_sel_reg + 1'b1;
      end else if (wr_en) begin
        // The last column is written once; col_full then blocks further writes.
        if (col_cnt_reg == COL_LAST) begin
          col_full_next = 1'b1;
        end else begin
          col_cnt_next = col_cnt_reg + 1'b1;
        end
      end
      if (bus.dv_i && col_full_reg) begin
        ovf_next = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mem
      line_mem #(
        .DATA_W (COLORDEPTH),
        .DEPTH  (LINE_W),
        .ADDR_W (ADDR_W)
      ) u_mem (
        .clk   (clk),
        .we    (wr_en && (wr_sel_reg == SEL_W'(gi))),
        .addr  (col_cnt_reg),
        .wdata (bus.px_i),
        .rdata (rd_data[gi])
      );
    end
  endgenerate

  assign row_cand[0]  = px_p1_reg;
  assign vect_next[0] = row_cand[0];

`ifdef LINEBUF_EDGE_REP_EN
  assign row_fill = row_cand[lc_p1_reg];
`else
  assign row_fill = '0;
`endif

  // Rows above the top of the frame (k > line count of this pixel) are masked.
  generate
    for (gi = 1; gi < M_DEPTH; gi++) begin : g_row
      assign row_cand[gi]  = rd_data[SEL_W'(ring_idx(int'(sel_p1_reg), gi, N))];
      assign vect_next[gi] = (LC_W'(gi) <= lc_p1_reg) ? row_cand[gi] : row_fill;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_cnt_reg  <= '0;
      col_full_reg <= 1'b0;
      line_cnt_reg <= '0;
      wr_sel_reg   <= '0;
      ovf_reg      <= 1'b0;
      sync_p1_reg  <= '0;
      sync_o_reg   <= '0;
      ovf_o_reg    <= 1'b0;
      px_p1_reg    <= '0;
      lc_p1_reg    <= '0;
      sel_p1_reg   <= '0;
      vect_reg     <= '0;
    end else begin
      col_cnt_reg  <= col_cnt_next;
      col_full_reg <= col_full_next;
      line_cnt_reg <= line_cnt_next;
      wr_sel_reg   <= wr_sel_next;
      ovf_reg      <= ovf_next;
      sync_p1_reg  <= '{dv: bus.dv_i, hs: bus.hs_i, vs: bus.vs_i};
      sync_o_reg   <= sync_p1_reg;
      // ovf takes one more stage so it lines up with dv_o/vs_o of the causing cycle.
      ovf_o_reg    <= ovf_reg;
      px_p1_reg    <= bus.px_i;
      lc_p1_reg    <= line_cnt_reg;
      sel_p1_reg   <= wr_sel_reg;
      for (int k = 0; k < M_DEPTH; k++) begin
        vect_reg[k] <= vect_next[k];
      end
    end
  end

  assign bus.vect_o = vect_reg;
  assign bus.dv_o   = sync_o_reg.dv;
  assign bus.hs_o   = sync_o_reg.hs;
  assign bus.vs_o   = sync_o_reg.vs;
  assign bus.ovf_o  = ovf_o_reg;

endmodule

// File: tb/tb_linebuf_col_gen.sv
// Self-checking bench for linebuf_col_gen: directed frames plus random frames against a line-history model.
module tb_linebuf_col_gen;
  import linebuf_pkg::*;

  localparam int CD = 8;
  localparam int MD = 3;
  localparam int LW = 8;

  typedef struct packed {
    logic           dv;
    logic           hs;
    logic           vs;
    logic           ovf;
    logic [MD-1:0]  chk;
    logic [MD-1:0][CD-1:0] v;
  } exp_t;

  logic clk;
  logic rst_n;

  linebuf_col_gen_if #(.COLORDEPTH(CD), .M_DEPTH(MD)) bus ();

  linebuf_col_gen #(
    .COLORDEPTH (CD),
    .M_DEPTH    (MD),
    .LINE_W     (LW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  exp_t   q[$];
  int     ln, cp;
  logic   prev_dv, prev_vs, m_ovf;
  pixel_t hist [64][16];
  int     hlen [64];

  task automatic model_reset();
    ln = 0; cp = 0; prev_dv = 1'b0; prev_vs = 1'b0; m_ovf = 1'b0;
    for (int i = 0; i < 64; i++) hlen[i] = 0;
  endtask

  task automatic check_exp(input exp_t e);
    total++;
    assert (bus.dv_o === e.dv) else begin
      bad++; $error("FAIL dv_o got=%0b want=%0b", bus.dv_o, e.dv);
    end
    total++;
    assert (bus.hs_o === e.hs) else begin
      bad++; $error("FAIL hs_o got=%0b want=%0b", bus.hs_o, e.hs);
    end
    total++;
    assert (bus.vs_o === e.vs) else begin
      bad++; $error("FAIL vs_o got=%0b want=%0b", bus.vs_o, e.vs);
    end
    total++;
    assert (bus.ovf_o === e.ovf) else begin
      bad++; $error("FAIL ovf_o got=%0b want=%0b", bus.ovf_o, e.ovf);
    end
    for (int k = 0; k < MD; k++) begin
      if (e.chk[k]) begin
        total++;
        assert (bus.vect_o[k] === e.v[k]) else begin
          bad++; $error("FAIL vect_o[%0d] got=%02h want=%02h", k, bus.vect_o[k], e.v[k]);
        end
      end
    end
  endtask

  // Drive one input cycle and queue what must appear on the outputs two cycles later.
  task automatic drive(input logic dv, input logic hs, input logic vs, input pixel_t px);
    exp_t   e;
    int     lc;
    pixel_t row [MD];
    bit     rowok [MD];
    bit     vs_rise, dv_fall;
    bus.dv_i = dv; bus.hs_i = hs; bus.vs_i = vs; bus.px_i = px;
    vs_rise = vs && !prev_vs;
    dv_fall = prev_dv && !dv;
    e = '0;
    e.dv = dv; e.hs = hs; e.vs = vs;
    if (dv) begin
      lc = (ln < MD - 1) ? ln : MD - 1;
      for (int j = 0; j < MD; j++) begin row[j] = '0; rowok[j] = 1'b0; end
      row[0] = px; rowok[0] = 1'b1;
      for (int j = 1; j <= lc; j++) begin
        rowok[j] = (cp < LW) && (cp < hlen[ln-j]);
        if (cp < LW) row[j] = hist[ln-j][cp];
      end
      for (int k = 0; k < MD; k++) begin
        if (k <= lc) begin
          e.v[k] = row[k]; e.chk[k] = rowok[k];
        end else begin
`ifdef LINEBUF_EDGE_REP_EN
          e.v[k] = row[lc]; e.chk[k] = rowok[lc];
`else
          e.v[k] = '0; e.chk[k] = 1'b1;
`endif
        end
      end
    end
    if (vs_rise) m_ovf = 1'b0;
    else if (dv && cp >= LW) m_ovf = 1'b1;
    e.ovf = m_ovf;
    if (dv && cp < LW) hist[ln][cp] = px;
    if (dv) cp++;
    if (vs_rise) begin
      ln = 0; cp = 0;
    end else if (dv_fall) begin
      hlen[ln] = cp;
      if (ln < 63) ln++;
      cp = 0;
    end
    prev_dv = dv; prev_vs = vs;
    q.push_back(e);
  endtask

  task automatic wait_check();
    @(posedge clk); #1;
    if (q.size() >= 2) check_exp(q.pop_front());
  endtask

  task automatic tick(input logic dv, input logic hs, input logic vs, input pixel_t px);
    wait_check();
    drive(dv, hs, vs, px);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.px_i = '0;
    @(posedge clk); #1;
    total++;
    assert (bus.vect_o === '0) else begin
      bad++; $error("FAIL rst_vect got=%06h want=000000", bus.vect_o);
    end
    total++;
    assert (bus.dv_o === 1'b0) else begin
      bad++; $error("FAIL rst_dv got=%0b want=0", bus.dv_o);
    end
    total++;
    assert (bus.hs_o === 1'b0) else begin
      bad++; $error("FAIL rst_hs got=%0b want=0", bus.hs_o);
    end
    total++;
    assert (bus.vs_o === 1'b0) else begin
      bad++; $error("FAIL rst_vs got=%0b want=0", bus.vs_o);
    end
    total++;
    assert (bus.ovf_o === 1'b0) else begin
      bad++; $error("FAIL rst_ovf got=%0b want=0", bus.ovf_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    q.delete();
    q.push_back('0);
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic send_pixels(input int len, input int base, input bit rnd);
    for (int c = 0; c < len; c++) begin
      tick(1'b1, rnd ? 1'($urandom) : 1'b0, 1'b0, rnd ? 8'($urandom) : 8'(base + c));
    end
  endtask

  task automatic send_line(input int len, input int base, input bit rnd);
    $display("line len=%0d base=%02h rnd=%0b", len, base, rnd);
    send_pixels(len, base, rnd);
    tick(1'b0, 1'b1, 1'b0, '0);
    for (int g = 0; g < (rnd ? $urandom_range(0, 2) : 1); g++) tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic vs_pulse();
    tick(1'b0, 1'b0, 1'b1, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.dv_i = 1'b0; bus.hs_i = 1'b0; bus.vs_i = 1'b0; bus.px_i = '0;
    model_reset();
    do_reset();

    // px = 16*line + col over three 4-pixel lines
    vs_pulse();
    for (int l = 0; l < 3; l++) send_line(4, 16 * l, 1'b0);

    // overflow: 10-pixel lines into 8-deep memories, held until next vs
    vs_pulse();
    send_line(10, 8'h40, 1'b0);
    send_line(10, 8'h60, 1'b0);
    send_line(4, 8'h80, 1'b0);
    vs_pulse();
    send_line(5, 8'h90, 1'b0);

    // vs rising in the same cycle as dv falling
    send_line(5, 8'ha0, 1'b0);
    send_pixels(5, 8'hb0, 1'b0);
    tick(1'b0, 1'b0, 1'b1, '0);
    tick(1'b0, 1'b0, 1'b0, '0);
    send_line(5, 8'hc0, 1'b0);
    send_line(5, 8'hd0, 1'b0);

    // reset mid-line, then restart
    send_pixels(3, 8'he0, 1'b0);
    do_reset();
    vs_pulse();
    send_line(1, 8'h05, 1'b0);
    send_line(3, 8'h15, 1'b0);
    send_line(3, 8'h25, 1'b0);

    for (int f = 0; f < 6; f++) begin
      vs_pulse();
      for (int l = 0; l < int'($urandom_range(2, 5)); l++) begin
        send_line($urandom_range(1, 10), 0, 1'b1);
      end
    end

    for (int i = 0; i < 4; i++) tick(1'b0, 1'b0, 1'b0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
